// File: rtl/serial_mult_pkg.sv
// Shared definitions for the serial multiplier arbiter: default sizes,
// FSM state encodings and a one-hot helper.
package serial_mult_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_WIDTH   = 4;
    localparam int DEF_TIMEOUT = 32;
    localparam int MAX_NREQ    = 8;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_RUN_ENC   = 2'd1;
    localparam logic [1:0] ST_ABORT_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_RUN   = ST_RUN_ENC,
        ST_ABORT = ST_ABORT_ENC
    } state_e;

    // Bit idx set, or all-zero when idx is outside the n active requesters.
    function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_NREQ-1:0] v;
        v = '0;
        if (idx < n) begin
            v = MAX_NREQ'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/serial_mult_rr_pick.sv
// Round-robin picker: the first set request bit strictly after last_grant,
// wrapping modulo NREQ.
module serial_mult_rr_pick
    import serial_mult_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic [$clog2(NREQ)-1:0] winner,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                sh;

    // Rotate so that bit 0 of rot is the requester just after last_grant.
    always_comb begin
        sh  = int'(last_grant) + 1;
        dbl = {req, req};
        rot = NREQ'(dbl >> sh);
    end

    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && rot[k]) begin
                any    = 1'b1;
                winner = IW'((sh + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/serial_mult_arbiter.sv
// Shares one serial shift-add multiplier between NREQ requesters: round-robin
// grant, operand capture, start pulse, result return and timeout abort.
module serial_mult_arbiter
    import serial_mult_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    Rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]      rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    mul_en,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    output logic                    mul_rst,
    input  logic                    mul_done,
    input  logic [2*WIDTH-1:0]      mul_product,
    output logic [1:0]              dbg_state
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);

    // Handshake: req is a level request sampled only in IDLE; ack is a 1-cycle
    // pulse meaning the operands were captured; exactly one rsp_valid pulse
    // follows on the same requester bit, with rsp_err marking a timeout abort.

    state_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [IW-1:0]       last_grant_q, last_grant_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                busy_q, busy_d;
    logic                mul_en_q, mul_en_d;
    logic                mul_rst_q, mul_rst_d;
    logic [WIDTH-1:0]    mul_a_q, mul_a_d;
    logic [WIDTH-1:0]    mul_b_q, mul_b_d;

    logic [IW-1:0]       win_idx;
    logic                win_any;
    logic [WIDTH-1:0]    sel_a, sel_b;

    serial_mult_rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .winner     (win_idx),
        .any        (win_any)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == win_idx) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        ack_d        = '0;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = 1'b0;
        busy_d       = busy_q;
        mul_en_d     = 1'b0;
        mul_rst_d    = 1'b0;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    ack_d    = NREQ'(onehot(int'(win_idx), NREQ));
                    grant_d  = win_idx;
                    mul_a_d  = sel_a;
                    mul_b_d  = sel_b;
                    mul_en_d = 1'b1;
                    timer_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                timer_d = timer_q + TW'(1);
                // A done arriving on the last allowed cycle still completes normally.
                if (mul_done) begin
                    rsp_valid_d  = NREQ'(onehot(int'(grant_q), NREQ));
                    rsp_data_d   = mul_product;
                    last_grant_d = grant_q;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    mul_rst_d = 1'b1;
                    state_d   = ST_ABORT;
                end
            end
            ST_ABORT: begin
                rsp_valid_d  = NREQ'(onehot(int'(grant_q), NREQ));
                rsp_err_d    = 1'b1;
                rsp_data_d   = '0;
                last_grant_d = grant_q;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            last_grant_q <= IW'(NREQ - 1);
            grant_q      <= '0;
            ack_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            mul_en_q     <= 1'b0;
            mul_rst_q    <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
            mul_en_q     <= mul_en_d;
            mul_rst_q    <= mul_rst_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
        end
    end

    assign ack       = ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign mul_en    = mul_en_q;
    assign mul_rst   = mul_rst_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign dbg_state = state_q;

endmodule
